// File: rtl/xyz_pkg.sv
// ============================================================================
// Module : xyz_pkg
// Desc   : Shared types for the {x,y,z} result-capture stage and its consumers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package xyz_pkg;

  typedef logic [2:0] xyz_t;

  localparam int XYZ_X     = 2;
  localparam int XYZ_Y     = 1;
  localparam int XYZ_Z     = 0;
  localparam int XYZ_TAG_W = 8;

  typedef struct packed {
    xyz_t                 vec;
    logic [XYZ_TAG_W-1:0] tag;
  } entry_t;

  function automatic xyz_t pack_xyz(input logic x, input logic y, input logic z);
    xyz_t v;
    v        = '0;
    v[XYZ_X] = x;
    v[XYZ_Y] = y;
    v[XYZ_Z] = z;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xyz_result_capture_if.sv
// ============================================================================
// Module : xyz_result_capture_if
// Desc   : Producer/consumer handshake bundle of the result-capture stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface xyz_result_capture_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_x;
  logic               in_y;
  logic               in_z;
  logic               change_only;
  logic               clr_ovf;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_data;
  logic [TAG_W-1:0]   out_tag;
  logic [LEVEL_W-1:0] level;
  logic               overflow;

  modport master (
    output in_valid, in_x, in_y, in_z, change_only, clr_ovf, out_ready,
    input  in_ready, out_valid, out_data, out_tag, level, overflow
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z, change_only, clr_ovf, out_ready,
    output in_ready, out_valid, out_data, out_tag, level, overflow
  );

endinterface

`default_nettype wire

// File: rtl/xyz_result_capture_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Desc   : Single-clock FIFO; extra pointer MSB separates full from empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push_i,
  input  wire logic [WIDTH-1:0]           wdata_i,
  input  wire logic                       pop_i,
  output logic      [WIDTH-1:0]           rdata_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // An empty FIFO presents zeros rather than stale storage.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/xyz_result_capture.sv
// ============================================================================
// Module : xyz_result_capture
// Desc   : Tags and buffers {x,y,z} samples with change filter and sticky overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xyz_result_capture
  import xyz_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input wire logic             clk,
  input wire logic             rst,
  xyz_result_capture_if.slave  bus
);

  localparam int WIDTH   = 3 + TAG_W;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0]   cnt_q, cnt_d;
  xyz_t               last_q, last_d;
  logic               have_last_q, have_last_d;
  logic               ovf_q, ovf_d;

  xyz_t               vec;
  logic               filtered, push, drop, pop;
  logic               full, empty;
  logic [WIDTH-1:0]   rdata;
  logic [LEVEL_W-1:0] level;

  assign vec      = pack_xyz(bus.in_x, bus.in_y, bus.in_z);
  assign filtered = bus.change_only && have_last_q && (vec == last_q);
  assign push     = bus.in_valid && !filtered && !full;
  assign drop     = bus.in_valid && !filtered && full;
  assign pop      = !empty && bus.out_ready;

  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    ovf_d       = ovf_q;
    // Every offered sample consumes a tag, even when filtered or dropped.
    if (bus.in_valid) cnt_d = cnt_q + 1'b1;
    if (push) begin
      last_d      = vec;
      have_last_d = 1'b1;
    end
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({vec, cnt_q}),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = rdata[TAG_W +: 3];
  assign bus.out_tag   = rdata[TAG_W-1:0];
  assign bus.level     = level;
  assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_xyz_result_capture.sv
// ============================================================================
// Module : tb_xyz_result_capture
// Desc   : Directed stimulus with queued expectations checked by a popping monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xyz_result_capture;

  logic clk;
  logic rst;

  xyz_result_capture_if #(.DEPTH(4), .TAG_W(8)) bus ();

  xyz_result_capture #(.DEPTH(4), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [10:0] sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation whenever the DUT hands over its head entry.
  task automatic monitor();
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got %b/%0d expected nothing", bus.out_data, bus.out_tag);
        end else begin
          exp = sb.pop_front();
          if ({bus.out_data, bus.out_tag} !== exp) begin
            n_err++;
            $display("FAIL pop_data: got %b/%0d expected %b/%0d",
                     bus.out_data, bus.out_tag, exp[10:8], exp[7:0]);
          end
        end
      end
    end
  endtask

  // etag < 0 means the sample must not reach the output.
  task automatic send(input logic [2:0] v, input int etag);
    bus.in_valid = 1'b1;
    {bus.in_x, bus.in_y, bus.in_z} = v;
    if (etag >= 0) sb.push_back({v, 8'(etag)});
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    bus.out_ready = 1'b1;
    k = 0;
    while (bus.out_valid && k < 50) begin
      tick();
      k++;
    end
    bus.out_ready = 1'b0;
    check({name, "_empty"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_x        = 1'b0;
    bus.in_y        = 1'b0;
    bus.in_z        = 1'b0;
    bus.change_only = 1'b0;
    bus.clr_ovf     = 1'b0;
    bus.out_ready   = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_level",     {29'd0, bus.level},     32'd0);
    check("rst_overflow",  {31'd0, bus.overflow},  32'd0);
    check("rst_out_tag",   {24'd0, bus.out_tag},   32'd0);
    check("rst_out_data",  {29'd0, bus.out_data},  32'd0);
    rst = 1'b0;

    // Two pushes, one-cycle latency, ordered drain
    send(3'b101, 0);
    check("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lat_out_data",  {29'd0, bus.out_data},  32'b101);
    send(3'b010, 1);
    check("two_level",     {29'd0, bus.level},     32'd2);
    check("two_head_tag",  {24'd0, bus.out_tag},   32'd0);
    drain("two");

    // Fill past capacity
    do_reset();
    send(3'b001, 0);
    send(3'b010, 1);
    send(3'b011, 2);
    send(3'b100, 3);
    send(3'b101, -1);
    check("full_level",    {29'd0, bus.level},     32'd4);
    check("full_in_ready", {31'd0, bus.in_ready},  32'd0);
    check("full_overflow", {31'd0, bus.overflow},  32'd1);
    drain("full");
    check("ovf_sticky",    {31'd0, bus.overflow},  32'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_cleared",   {31'd0, bus.overflow},  32'd0);

    // Change-only filtering
    do_reset();
    bus.change_only = 1'b1;
    send(3'b011, 0);
    send(3'b011, -1);
    send(3'b011, -1);
    send(3'b100, 3);
    check("filt_level",    {29'd0, bus.level},     32'd2);
    check("filt_overflow", {31'd0, bus.overflow},  32'd0);
    drain("filt");
    bus.change_only = 1'b0;

    // Steady push+pop at level 2, then push into full with pop
    do_reset();
    send(3'b111, 0);
    send(3'b110, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(3'(i), i + 2);
      check("steady_level", {29'd0, bus.level}, 32'd2);
    end
    bus.out_ready = 1'b0;
    send(3'b001, 12);
    send(3'b010, 13);
    check("fill_level",    {29'd0, bus.level},     32'd4);
    bus.out_ready = 1'b1;
    send(3'b011, -1);
    bus.out_ready = 1'b0;
    check("fullpop_level", {29'd0, bus.level},     32'd3);
    check("fullpop_ovf",   {31'd0, bus.overflow},  32'd1);
    drain("fullpop");

    // Reset mid-drain
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(3'b001, i);
    drain("pre");
    send(3'b100, 4);
    send(3'b101, 5);
    send(3'b110, 6);
    check("mid_level",     {29'd0, bus.level},     32'd3);
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    sb.delete();
    check("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_level0",    {29'd0, bus.level},     32'd0);
    rst = 1'b0;
    bus.change_only = 1'b1;
    send(3'b110, 0);
    check("post_tag",      {24'd0, bus.out_tag},   32'd0);
    check("post_level",    {29'd0, bus.level},     32'd1);
    send(3'b110, -1);
    check("post_filt_lvl", {29'd0, bus.level},     32'd1);
    drain("post");
    bus.change_only = 1'b0;

    tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
